// File: rtl/xbar_ingress_stage_if.sv
// Signal bundle between a line-card stream, the crossbar arbiter
// and the crossbar data path for one ingress stage.
interface xbar_ingress_stage_if #(
    parameter int PORT_BITS = 6
);
    logic                 s_tvalid;
    logic                 s_tready;
    logic [63:0]          s_tdata;
    logic [7:0]           s_tkeep;
    logic                 s_tlast;
    logic [PORT_BITS:0]   s_tdest;
    logic [11:0]          s_tuser;
    logic                 xbar_req;
    logic [PORT_BITS:0]   xbar_req_dest;
    logic                 xbar_grant;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [63:0]          m_tdata;
    logic [7:0]           m_tkeep;
    logic                 m_tlast;
    logic [11:0]          m_tuser;
    logic                 frame_drop;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tdest, s_tuser,
        input  xbar_grant, m_tready,
        output s_tready, xbar_req, xbar_req_dest,
        output m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, frame_drop
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tdest, s_tuser,
        output xbar_grant, m_tready,
        input  s_tready, xbar_req, xbar_req_dest,
        input  m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, frame_drop
    );
endinterface

// File: rtl/xbar_ingress_stage.sv
// Store-and-forward ingress: buffers whole frames, requests a crossbar
// port per frame and streams it out once granted.
module xbar_ingress_stage #(
    parameter int DEPTH      = 512,
    parameter int DESC_DEPTH = 16,
    parameter int PORT_BITS  = 6
) (
    input  logic clk,
    input  logic areset_n,
    xbar_ingress_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);
    localparam int TW = PORT_BITS + 1;
    localparam int EW = TW + 12 + AW + 1;

    localparam logic [AW:0]   P1    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] A1    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW:0]   D1    = {{DW{1'b0}}, 1'b1};
    localparam logic [DW:0]   DFULL = {1'b1, {DW{1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [71:0]   mem  [DEPTH];
    logic [EW-1:0] desc [DESC_DEPTH];

    logic [AW:0]   wr_ptr, wr_commit, rd_ptr;
    logic [DW:0]   dwr, drd;
    logic          in_frame, dropping;
    logic [TW-1:0] cur_dest, f_dest;
    logic [11:0]   cur_vlan, f_vlan;
    logic          acc, first, buf_full, desc_full, desc_empty;
    logic          discard, wr_en, push;
    logic [AW:0]   wcount;

    logic [1:0]    state;
    logic [AW-1:0] fptr;
    logic [AW:0]   fetch_left, out_left;
    logic [11:0]   out_vlan;
    logic          rv, re, grant_ok, hs, last_hs, space;
    logic [AW-1:0] raddr;
    logic [71:0]   rd_q, sk0, sk1;
    logic [1:0]    sc;
    logic [2:0]    occ;
    logic [EW-1:0] head;
    logic [TW-1:0] h_dest;
    logic [11:0]   h_vlan;
    logic [AW:0]   h_cnt;

    assign acc        = bus.s_tvalid & areset_n;
    assign first      = ~in_frame;
    assign buf_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign desc_full  = (dwr - drd) == DFULL;
    assign desc_empty = dwr == drd;
    assign discard    = dropping | (first & desc_full) | buf_full;
    assign wr_en      = acc & ~discard;
    assign push       = wr_en & bus.s_tlast;
    assign wcount     = wr_ptr - wr_commit + P1;
    assign f_dest     = first ? bus.s_tdest : cur_dest;
    assign f_vlan     = first ? bus.s_tuser : cur_vlan;

    // Speculative writes are undone by rewinding to the last committed frame end
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            dwr       <= '0;
            in_frame  <= 1'b0;
            dropping  <= 1'b0;
            cur_dest  <= '0;
            cur_vlan  <= '0;
        end else if (acc) begin
            in_frame <= ~bus.s_tlast;
            if (first) begin
                cur_dest <= bus.s_tdest;
                cur_vlan <= bus.s_tuser;
            end
            if (discard) begin
                wr_ptr   <= wr_commit;
                dropping <= ~bus.s_tlast;
            end else begin
                wr_ptr <= wr_ptr + P1;
                if (bus.s_tlast) begin
                    wr_commit <= wr_ptr + P1;
                    dwr       <= dwr + D1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {bus.s_tkeep, bus.s_tdata};
        if (push)
            desc[dwr[DW-1:0]] <= {f_dest, f_vlan, wcount};
        if (re)
            rd_q <= mem[raddr];
    end

    assign head     = desc[drd[DW-1:0]];
    assign h_dest   = head[EW-1 -: TW];
    assign h_vlan   = head[AW+12 -: 12];
    assign h_cnt    = head[AW:0];
    assign grant_ok = (state == REQ) & bus.xbar_grant;
    assign hs       = bus.m_tvalid & bus.m_tready;
    assign last_hs  = hs & (out_left == P1);
    assign occ      = {1'b0, sc} + {2'b00, rv} - {2'b00, hs};
    assign space    = occ < 3'd2;
    // First word is fetched in the grant cycle itself to meet output latency
    assign re       = grant_ok |
                      ((state == SEND) & (fetch_left != '0) & space);
    assign raddr    = grant_ok ? rd_ptr[AW-1:0] : fptr;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            fptr       <= '0;
            fetch_left <= '0;
            out_left   <= '0;
            out_vlan   <= '0;
            drd        <= '0;
            rv         <= 1'b0;
            sc         <= '0;
            sk0        <= '0;
            sk1        <= '0;
        end else begin
            rv <= re;
            case (state)
                IDLE: if (!desc_empty) state <= REQ;
                REQ: if (bus.xbar_grant) begin
                    state      <= SEND;
                    fptr       <= rd_ptr[AW-1:0] + A1;
                    fetch_left <= h_cnt - P1;
                    out_left   <= h_cnt;
                    out_vlan   <= h_vlan;
                end
                SEND: begin
                    if (re) begin
                        fptr       <= fptr + A1;
                        fetch_left <= fetch_left - P1;
                    end
                    if (last_hs) begin
                        state <= IDLE;
                        drd   <= drd + D1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (hs) begin
                rd_ptr   <= rd_ptr + P1;
                out_left <= out_left - P1;
            end
            case ({rv, hs})
                2'b10: begin
                    if (sc == 2'd0) sk0 <= rd_q;
                    else            sk1 <= rd_q;
                    sc <= sc + 2'd1;
                end
                2'b01: begin
                    sk0 <= sk1;
                    sc  <= sc - 2'd1;
                end
                2'b11: begin
                    if (sc == 2'd1) sk0 <= rd_q;
                    else begin
                        sk0 <= sk1;
                        sk1 <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_tready      = areset_n;
    assign bus.xbar_req      = state == REQ;
    assign bus.xbar_req_dest = (state == REQ) ? h_dest : '0;
    assign bus.m_tvalid      = sc != 2'd0;
    assign bus.m_tdata       = sk0[63:0];
    assign bus.m_tkeep       = sk0[71:64];
    assign bus.m_tlast       = bus.m_tvalid & (out_left == P1);
    assign bus.m_tuser       = out_vlan;
    assign bus.frame_drop    = acc & bus.s_tlast & discard;
endmodule

// File: tb/tb_xbar_ingress_stage.sv
// Directed bench for the ingress stage: delivery, overflow drop,
// descriptor-full drop, backpressure, back-to-back and mid-frame reset.
module tb_xbar_ingress_stage;
    localparam int PB = 6;

    logic clk = 1'b0;
    logic areset_n = 1'b0;

    xbar_ingress_stage_if #(.PORT_BITS(PB)) bus ();

    xbar_ingress_stage #(
        .DEPTH(512), .DESC_DEPTH(16), .PORT_BITS(PB)
    ) dut (
        .clk(clk), .areset_n(areset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int drops, drop_at;
    logic req_seen, req_after, valid_after;
    logic [PB:0] req_dest;
    int got;
    logic [63:0] g_data [16];
    logic [7:0]  g_keep [16];
    logic        g_last [16];
    logic [11:0] g_user [16];

    function automatic logic [63:0] dv(input logic [15:0] tag, input int i);
        return {tag, 32'hC0DE_0000, i[15:0]};
    endfunction

    task automatic send_frame(input int n, input logic [15:0] tag,
                              input logic [PB:0] dest, input logic [11:0] vlan,
                              input logic [7:0] lkeep);
        drops = 0;
        drop_at = -1;
        for (int i = 0; i < n; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = dv(tag, i);
            bus.s_tkeep  = (i == n - 1) ? lkeep : 8'hFF;
            bus.s_tlast  = (i == n - 1);
            bus.s_tdest  = (i == 0) ? dest : 7'h7F;
            bus.s_tuser  = (i == 0) ? vlan : 12'hFFF;
            @(negedge clk);
            if (bus.frame_drop) begin
                drops++;
                drop_at = i;
            end
            @(posedge clk); #1;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic do_grant();
        int c = 0;
        req_seen = 1'b0;
        req_after = 1'b1;
        valid_after = 1'b0;
        req_dest = '0;
        while (!req_seen && c < 40) begin
            @(negedge clk);
            if (bus.xbar_req) begin
                req_seen = 1'b1;
                req_dest = bus.xbar_req_dest;
            end else c++;
        end
        if (req_seen) begin
            @(posedge clk); #1;
            bus.xbar_grant = 1'b1;
            @(posedge clk); #1;
            bus.xbar_grant = 1'b0;
            @(negedge clk);
            req_after = bus.xbar_req;
            @(posedge clk); #1;
            valid_after = bus.m_tvalid;
        end
    endtask

    task automatic collect(input int n, input bit tgl);
        int c = 0;
        got = 0;
        bus.m_tready = 1'b1;
        while (got < n && c < 200) begin
            @(negedge clk);
            if (bus.m_tvalid && bus.m_tready) begin
                g_data[got] = bus.m_tdata;
                g_keep[got] = bus.m_tkeep;
                g_last[got] = bus.m_tlast;
                g_user[got] = bus.m_tuser;
                got++;
            end
            @(posedge clk); #1;
            if (tgl) bus.m_tready = ~bus.m_tready;
            c++;
        end
        bus.m_tready = 1'b1;
    endtask

    task automatic test_reset();
        bus.s_tvalid = 1'b1;
        bus.s_tlast  = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.s_tready !== 1'b0) begin n_bad++;
            $display("FAIL rst_s_tready: got %b want 0", bus.s_tready); end
        n_cmp++; if (bus.xbar_req !== 1'b0) begin n_bad++;
            $display("FAIL rst_xbar_req: got %b want 0", bus.xbar_req); end
        n_cmp++; if (bus.xbar_req_dest !== 7'h00) begin n_bad++;
            $display("FAIL rst_req_dest: got %h want 00", bus.xbar_req_dest); end
        n_cmp++; if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin n_bad++;
            $display("FAIL rst_m_valid_last: got %b%b want 00", bus.m_tvalid, bus.m_tlast); end
        n_cmp++; if (bus.frame_drop !== 1'b0) begin n_bad++;
            $display("FAIL rst_frame_drop: got %b want 0", bus.frame_drop); end
        n_cmp++; if ({bus.m_tdata, bus.m_tkeep, bus.m_tuser} !== 84'h0) begin n_bad++;
            $display("FAIL rst_m_data: got %h %h %h want 0", bus.m_tdata, bus.m_tkeep, bus.m_tuser); end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        areset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.s_tready !== 1'b1) begin n_bad++;
            $display("FAIL run_s_tready: got %b want 1", bus.s_tready); end
    endtask

    task automatic test_basic();
        send_frame(3, 16'h0034, 7'h05, 12'h00A, 8'h0F);
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h05) begin n_bad++;
            $display("FAIL basic_req: got %b/%h want 1/05", req_seen, req_dest); end
        n_cmp++; if (req_after !== 1'b0) begin n_bad++;
            $display("FAIL basic_req_drop: got %b want 0", req_after); end
        n_cmp++; if (valid_after !== 1'b1) begin n_bad++;
            $display("FAIL basic_latency: got %b want 1", valid_after); end
        collect(3, 1'b0);
        n_cmp++; if (got != 3) begin n_bad++;
            $display("FAIL basic_count: got %0d want 3", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (g_data[i] !== dv(16'h0034, i) || g_keep[i] !== ((i == 2) ? 8'h0F : 8'hFF) ||
                g_last[i] !== (i == 2) || g_user[i] !== 12'h00A) begin
                n_bad++;
                $display("FAIL basic_beat%0d: got %h %h %b %h want %h %h %b 00a", i,
                         g_data[i], g_keep[i], g_last[i], g_user[i], dv(16'h0034, i),
                         (i == 2) ? 8'h0F : 8'hFF, (i == 2));
            end
        end
    endtask

    task automatic test_overflow();
        logic seen = 1'b0;
        send_frame(600, 16'h0035, 7'h11, 12'h123, 8'hFF);
        n_cmp++; if (drops != 1 || drop_at != 599) begin n_bad++;
            $display("FAIL ovf_drop: got %0d at %0d want 1 at 599", drops, drop_at); end
        repeat (10) begin
            @(negedge clk);
            if (bus.xbar_req) seen = 1'b1;
        end
        @(posedge clk); #1;
        n_cmp++; if (seen !== 1'b0) begin n_bad++;
            $display("FAIL ovf_no_req: got %b want 0", seen); end
        send_frame(4, 16'h0036, 7'h06, 12'h055, 8'h03);
        n_cmp++; if (drops != 0) begin n_bad++;
            $display("FAIL ovf_next_drop: got %0d want 0", drops); end
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h06) begin n_bad++;
            $display("FAIL ovf_req: got %b/%h want 1/06", req_seen, req_dest); end
        collect(4, 1'b0);
        n_cmp++; if (got != 4) begin n_bad++;
            $display("FAIL ovf_count: got %0d want 4", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (g_data[i] !== dv(16'h0036, i) || g_keep[i] !== ((i == 3) ? 8'h03 : 8'hFF) ||
                g_last[i] !== (i == 3) || g_user[i] !== 12'h055) begin
                n_bad++;
                $display("FAIL ovf_beat%0d: got %h %h %b %h want %h", i,
                         g_data[i], g_keep[i], g_last[i], g_user[i], dv(16'h0036, i));
            end
        end
    endtask

    task automatic test_desc_full();
        int tot = 0;
        int which = -1;
        logic seen = 1'b0;
        for (int f = 0; f < 17; f++) begin
            send_frame(1, 16'h1000 + f[15:0], f[6:0], 12'h200 + f[11:0], 8'h01);
            if (drops != 0) begin
                tot += drops;
                which = f;
            end
        end
        n_cmp++; if (tot != 1 || which != 16) begin n_bad++;
            $display("FAIL dfull_drop: got %0d at %0d want 1 at 16", tot, which); end
        for (int f = 0; f < 16; f++) begin
            do_grant();
            n_cmp++; if (req_seen !== 1'b1 || req_dest !== f[6:0]) begin n_bad++;
                $display("FAIL dfull_req%0d: got %b/%h want 1/%h", f, req_seen, req_dest, f[6:0]); end
            collect(1, 1'b0);
            n_cmp++;
            if (got != 1 || g_data[0] !== dv(16'h1000 + f[15:0], 0) || g_last[0] !== 1'b1 ||
                g_keep[0] !== 8'h01 || g_user[0] !== 12'h200 + f[11:0]) begin
                n_bad++;
                $display("FAIL dfull_beat%0d: got %0d %h %b %h want 1 %h 1 %h", f, got,
                         g_data[0], g_last[0], g_user[0], dv(16'h1000 + f[15:0], 0), 12'h200 + f[11:0]);
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (bus.xbar_req) seen = 1'b1;
        end
        @(posedge clk); #1;
        n_cmp++; if (seen !== 1'b0) begin n_bad++;
            $display("FAIL dfull_extra_req: got %b want 0", seen); end
    endtask

    task automatic test_backpressure();
        int extra = 0;
        send_frame(8, 16'h0037, 7'h08, 12'h0AB, 8'hFF);
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h08) begin n_bad++;
            $display("FAIL bp_req: got %b/%h want 1/08", req_seen, req_dest); end
        collect(8, 1'b1);
        n_cmp++; if (got != 8) begin n_bad++;
            $display("FAIL bp_count: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (g_data[i] !== dv(16'h0037, i) || g_last[i] !== (i == 7) || g_user[i] !== 12'h0AB) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got %h %b %h want %h %b 0ab", i,
                         g_data[i], g_last[i], g_user[i], dv(16'h0037, i), (i == 7));
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (bus.m_tvalid) extra++;
        end
        @(posedge clk); #1;
        n_cmp++; if (extra != 0) begin n_bad++;
            $display("FAIL bp_dup: got %0d extra want 0", extra); end
    endtask

    task automatic test_back_to_back();
        send_frame(2, 16'h0039, 7'h40, 12'h001, 8'hFF);
        send_frame(3, 16'h003A, 7'h02, 12'h002, 8'hFF);
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h40 || req_after !== 1'b0) begin n_bad++;
            $display("FAIL b2b_req1: got %b/%h/%b want 1/40/0", req_seen, req_dest, req_after); end
        collect(2, 1'b0);
        n_cmp++;
        if (got != 2 || g_data[0] !== dv(16'h0039, 0) || g_data[1] !== dv(16'h0039, 1) ||
            g_last[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_frame1: got %0d %h %h want 2 %h %h", got, g_data[0], g_data[1],
                     dv(16'h0039, 0), dv(16'h0039, 1));
        end
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h02 || req_after !== 1'b0) begin n_bad++;
            $display("FAIL b2b_req2: got %b/%h/%b want 1/02/0", req_seen, req_dest, req_after); end
        collect(3, 1'b0);
        n_cmp++;
        if (got != 3 || g_data[0] !== dv(16'h003A, 0) || g_data[2] !== dv(16'h003A, 2) ||
            g_last[2] !== 1'b1 || g_user[2] !== 12'h002) begin
            n_bad++;
            $display("FAIL b2b_frame2: got %0d %h %h want 3 %h %h", got, g_data[0], g_data[2],
                     dv(16'h003A, 0), dv(16'h003A, 2));
        end
    endtask

    task automatic test_reset_mid();
        logic sv = 1'b0;
        logic sr = 1'b0;
        send_frame(5, 16'h0038, 7'h09, 12'h0CC, 8'hFF);
        do_grant();
        collect(2, 1'b0);
        n_cmp++; if (got != 2) begin n_bad++;
            $display("FAIL mid_pre: got %0d want 2", got); end
        areset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_tvalid !== 1'b0 || bus.xbar_req !== 1'b0 || bus.m_tlast !== 1'b0 ||
            bus.s_tready !== 1'b0 || bus.frame_drop !== 1'b0 ||
            {bus.m_tdata, bus.m_tkeep, bus.m_tuser} !== 84'h0 || bus.xbar_req_dest !== 7'h00) begin
            n_bad++;
            $display("FAIL mid_rst_outs: got v%b r%b l%b t%b d%h u%h want all 0",
                     bus.m_tvalid, bus.xbar_req, bus.m_tlast, bus.s_tready, bus.m_tdata, bus.m_tuser);
        end
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_tvalid) sv = 1'b1;
            if (bus.xbar_req) sr = 1'b1;
        end
        @(posedge clk); #1;
        n_cmp++; if (sv !== 1'b0 || sr !== 1'b0) begin n_bad++;
            $display("FAIL mid_quiet: got valid %b req %b want 0 0", sv, sr); end
        send_frame(2, 16'h003B, 7'h0A, 12'h0DD, 8'hFF);
        do_grant();
        n_cmp++; if (req_seen !== 1'b1 || req_dest !== 7'h0A) begin n_bad++;
            $display("FAIL mid_req: got %b/%h want 1/0a", req_seen, req_dest); end
        collect(2, 1'b0);
        n_cmp++;
        if (got != 2 || g_data[0] !== dv(16'h003B, 0) || g_data[1] !== dv(16'h003B, 1) ||
            g_user[0] !== 12'h0DD) begin
            n_bad++;
            $display("FAIL mid_after: got %0d %h %h want 2 %h %h", got, g_data[0], g_data[1],
                     dv(16'h003B, 0), dv(16'h003B, 1));
        end
    endtask

    initial begin
        bus.s_tvalid   = 1'b0;
        bus.s_tdata    = '0;
        bus.s_tkeep    = '0;
        bus.s_tlast    = 1'b0;
        bus.s_tdest    = '0;
        bus.s_tuser    = '0;
        bus.xbar_grant = 1'b0;
        bus.m_tready   = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_desc_full();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
